// File: rtl/vic_scandoubler_if.sv
// Pixel-side bundle of the line doubler: native-rate capture inputs, output
// pixel strobe, and the doubled-rate video/status outputs.
interface vic_scandoubler_if;
   logic       in_pix_en;
   logic       in_line_start;
   logic [1:0] in_red;
   logic [1:0] in_green;
   logic [1:0] in_blue;
   logic       out_pix_en;
   logic [1:0] out_red;
   logic [1:0] out_green;
   logic [1:0] out_blue;
   logic       out_hsync;
   logic       out_active;
   logic [9:0] line_len;
   logic       overflow;

   modport master (
      output in_pix_en, in_line_start, in_red, in_green, in_blue, out_pix_en,
      input  out_red, out_green, out_blue, out_hsync, out_active, line_len, overflow
   );

   modport slave (
      input  in_pix_en, in_line_start, in_red, in_green, in_blue, out_pix_en,
      output out_red, out_green, out_blue, out_hsync, out_active, line_len, overflow
   );
endinterface

// File: rtl/vic_scandoubler.sv
// Ping-pong line buffer scan doubler: each captured line is replayed twice at the
// output strobe rate with its own hsync. VIC_SCANLINES_EN dims the second pass.
module vic_scandoubler #(
   parameter int MAX_PIXELS  = 520,
   parameter int HSYNC_WIDTH = 64,
   parameter int BP_WIDTH    = 24
) (
   input  logic             clk_dot4x,
   input  logic             rst,
   vic_scandoubler_if.slave bus
);
   localparam logic [9:0] C_MAX     = 10'(MAX_PIXELS);
   localparam logic [9:0] C_HS_LAST = 10'(HSYNC_WIDTH - 1);
   localparam logic [9:0] C_BP_LAST = 10'(BP_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PORCH, S_PASS, S_BLANK} state_t;

   logic [5:0] r_buf0 [MAX_PIXELS];
   logic [5:0] r_buf1 [MAX_PIXELS];

   logic       r_wr_sel;
   logic [9:0] r_wr_count;
   logic [9:0] r_line_len;
   logic       r_overflow;

   state_t     r_state, w_state_nx;
   logic [9:0] r_cnt, w_cnt_nx;
   logic [9:0] r_rd_addr, w_rd_addr_nx;
   logic       r_pass, w_pass_nx;
   logic       w_ld, w_act, w_hs;

   logic [5:0] r_rd_data;
   logic       r_s1_act, r_s1_hs;
   logic [5:0] r_out_rgb;
   logic       r_out_act, r_out_hs;

   logic [5:0] w_pix, w_pix_out, w_waddr_unused;
   logic       w_we, w_wsel;
   logic [9:0] w_waddr, w_last;

   assign w_pix   = {bus.in_red, bus.in_green, bus.in_blue};
   // A pixel arriving with the line start opens the new line at index 0.
   assign w_we    = !rst && bus.in_pix_en && (bus.in_line_start || (r_wr_count < C_MAX));
   assign w_wsel  = bus.in_line_start ? ~r_wr_sel : r_wr_sel;
   assign w_waddr = bus.in_line_start ? 10'd0 : r_wr_count;
   assign w_last  = r_line_len - 10'd1;
   assign w_waddr_unused = '0;

   always_ff @(posedge clk_dot4x) begin
      if (w_we) begin
         if (w_wsel) r_buf1[w_waddr] <= w_pix;
         else        r_buf0[w_waddr] <= w_pix;
      end
   end

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         r_wr_sel   <= 1'b0;
         r_wr_count <= '0;
         r_line_len <= '0;
         r_overflow <= 1'b0;
      end else if (bus.in_line_start) begin
         r_wr_sel   <= ~r_wr_sel;
         r_line_len <= r_wr_count;
         r_wr_count <= bus.in_pix_en ? 10'd1 : 10'd0;
      end else if (bus.in_pix_en) begin
         if (r_wr_count < C_MAX) r_wr_count <= r_wr_count + 10'd1;
         else                    r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rd_addr <= '0;
         r_pass    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_rd_addr <= w_rd_addr_nx;
         r_pass    <= w_pass_nx;
      end
   end

   // w_act/w_hs describe what this strobe presents; they land on the pins two cycles later.
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_rd_addr_nx = r_rd_addr;
      w_pass_nx    = r_pass;
      w_ld         = 1'b0;
      w_act        = 1'b0;
      w_hs         = 1'b1;
      if (bus.in_line_start) begin
         w_state_nx   = S_SYNC;
         w_cnt_nx     = '0;
         w_rd_addr_nx = '0;
         w_pass_nx    = 1'b0;
         w_ld         = 1'b1;
      end else if (bus.out_pix_en) begin
         w_ld = 1'b1;
         case (r_state)
            S_SYNC: begin
               w_hs = 1'b0;
               if (r_cnt == C_HS_LAST) begin
                  w_state_nx = S_PORCH;
                  w_cnt_nx   = '0;
               end else begin
                  w_cnt_nx = r_cnt + 10'd1;
               end
            end
            S_PORCH: begin
               if (r_cnt != C_BP_LAST) begin
                  w_cnt_nx = r_cnt + 10'd1;
               end else begin
                  w_cnt_nx = '0;
                  if (r_line_len != 10'd0) begin
                     w_state_nx = S_PASS;
                  end else if (!r_pass) begin
                     w_pass_nx  = 1'b1;
                     w_state_nx = S_SYNC;
                  end else begin
                     w_state_nx = S_BLANK;
                  end
               end
            end
            S_PASS: begin
               w_act = 1'b1;
               if (r_rd_addr == w_last) begin
                  w_rd_addr_nx = '0;
                  w_pass_nx    = 1'b1;
                  w_state_nx   = r_pass ? S_BLANK : S_SYNC;
               end else begin
                  w_rd_addr_nx = r_rd_addr + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_dot4x) begin
      if (w_ld) r_rd_data <= r_wr_sel ? r_buf0[r_rd_addr] : r_buf1[r_rd_addr];
   end

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         r_s1_act <= 1'b0;
         r_s1_hs  <= 1'b1;
      end else if (w_ld) begin
         r_s1_act <= w_act;
         r_s1_hs  <= w_hs;
      end
   end

`ifdef VIC_SCANLINES_EN
   logic r_s1_pass;
   always_ff @(posedge clk_dot4x) begin
      if (rst)       r_s1_pass <= 1'b0;
      else if (w_ld) r_s1_pass <= r_pass;
   end
   assign w_pix_out = r_s1_pass ? {1'b0, r_rd_data[5], 1'b0, r_rd_data[3], 1'b0, r_rd_data[1]}
                                : r_rd_data;
`else
   assign w_pix_out = r_rd_data;
`endif

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         r_out_rgb <= '0;
         r_out_act <= 1'b0;
         r_out_hs  <= 1'b1;
      end else begin
         r_out_rgb <= r_s1_act ? w_pix_out : 6'd0;
         r_out_act <= r_s1_act;
         r_out_hs  <= r_s1_hs;
      end
   end

   assign bus.out_red    = r_out_rgb[5:4];
   assign bus.out_green  = r_out_rgb[3:2];
   assign bus.out_blue   = r_out_rgb[1:0];
   assign bus.out_active = r_out_act;
   assign bus.out_hsync  = r_out_hs;
   assign bus.line_len   = r_line_len;
   assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_vic_scandoubler.sv
// Bench for vic_scandoubler: a queue model of the replay schedule checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_vic_scandoubler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vic_scandoubler_if bus();
   vic_scandoubler dut (.clk_dot4x(clk), .rst(rst), .bus(bus));

   typedef struct packed {logic [5:0] rgb; logic act; logic hs;} px_t;
   localparam px_t BLANK = '{6'd0, 1'b0, 1'b1};
   localparam px_t SYNCP = '{6'd0, 1'b0, 1'b0};
`ifdef VIC_SCANLINES_EN
   localparam bit SCAN = 1'b1;
`else
   localparam bit SCAN = 1'b0;
`endif

   int nchk = 0, nerr = 0;
   bit gen = 0, chk_on = 0, en_d1 = 0, en_d2 = 0;
   px_t m_q[$];
   px_t m_pend = BLANK, m_exp = BLANK;
   logic [5:0] m_wq[$];
   int m_len = 0;
   bit m_ovf = 0;
   logic [5:0] dut_px[$];
   int hs_low = 0;

   task automatic check(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] dim(input logic [5:0] v);
      logic [1:0] r, g, b;
      r = v[5:4] / 2; g = v[3:2] / 2; b = v[1:0] / 2;
      return {r, g, b};
   endfunction

   // Every completed line becomes a fixed list of strobe presentations.
   task automatic build_schedule();
      m_q.delete();
      for (int p = 0; p < 2; p++) begin
         repeat (64) m_q.push_back(SYNCP);
         repeat (24) m_q.push_back(BLANK);
         foreach (m_wq[i])
            m_q.push_back(px_t'{(p == 1 && SCAN) ? dim(m_wq[i]) : m_wq[i], 1'b1, 1'b1});
      end
   endtask

   always @(posedge clk) begin
      m_exp = m_pend;
      en_d2 = en_d1;
      en_d1 = bus.out_pix_en;
      if (rst) begin
         chk_on = 1;
         m_exp  = BLANK;
         m_pend = BLANK;
         m_q.delete();
         m_wq.delete();
         m_len  = 0;
         m_ovf  = 0;
      end else if (bus.in_line_start) begin
         m_len = m_wq.size();
         build_schedule();
         m_wq.delete();
         m_pend = BLANK;
         if (bus.in_pix_en) m_wq.push_back({bus.in_red, bus.in_green, bus.in_blue});
      end else begin
         if (bus.out_pix_en) m_pend = (m_q.size() > 0) ? m_q.pop_front() : BLANK;
         if (bus.in_pix_en) begin
            if (m_wq.size() < 520) m_wq.push_back({bus.in_red, bus.in_green, bus.in_blue});
            else m_ovf = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("video", int'({bus.out_red, bus.out_green, bus.out_blue, bus.out_active, bus.out_hsync}),
               int'(m_exp));
         check("line_len", int'(bus.line_len), m_len);
         check("overflow", int'(bus.overflow), int'(m_ovf));
         if (en_d2) begin
            if (bus.out_active) dut_px.push_back({bus.out_red, bus.out_green, bus.out_blue});
            if (!bus.out_hsync) hs_low++;
         end
      end
   end

   always @(negedge clk) bus.out_pix_en = gen ? ~bus.out_pix_en : 1'b0;

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic wr_px(input logic [5:0] v);
      bus.in_pix_en = 1'b1;
      {bus.in_red, bus.in_green, bus.in_blue} = v;
      step();
      bus.in_pix_en = 1'b0;
   endtask

   task automatic ls(input bit wp, input logic [5:0] v);
      bus.in_line_start = 1'b1;
      bus.in_pix_en     = wp;
      {bus.in_red, bus.in_green, bus.in_blue} = v;
      step();
      bus.in_line_start = 1'b0;
      bus.in_pix_en     = 1'b0;
   endtask

   task automatic wait_px(input int n, input int budget);
      for (int k = 0; k < budget && dut_px.size() < n; k++) step();
      check("wait_px_timeout", int'(dut_px.size() >= n), 1);
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_active"}, int'(bus.out_active), 0);
      check({tag, "_hsync"}, int'(bus.out_hsync), 1);
      check({tag, "_rgb"}, int'({bus.out_red, bus.out_green, bus.out_blue}), 0);
      check({tag, "_len"}, int'(bus.line_len), 0);
      check({tag, "_ovf"}, int'(bus.overflow), 0);
   endtask

   initial begin
      bus.in_pix_en = 0; bus.in_line_start = 0; bus.out_pix_en = 0;
      bus.in_red = 0; bus.in_green = 0; bus.in_blue = 0;
      rst = 1'b1;
      repeat (3) step();
      check_reset_pins("reset");
      rst = 1'b0;
      gen = 1'b1;

      // basic doubling
      wr_px(6'h3F); wr_px(6'h30); wr_px(6'h0C); wr_px(6'h03);
      dut_px.delete(); hs_low = 0;
      ls(0, 6'h00);
      check("basic_len", int'(bus.line_len), 4);
      repeat (400) step();
      check("basic_npx", dut_px.size(), 8);
      check("basic_hs_strobes", hs_low, 128);
      if (dut_px.size() == 8) begin
         check("basic_p0", dut_px[0], 6'h3F);
         check("basic_p1", dut_px[1], 6'h30);
         check("basic_p2", dut_px[2], 6'h0C);
         check("basic_p3", dut_px[3], 6'h03);
         check("basic_q0", dut_px[4], SCAN ? 6'h15 : 6'h3F);
         check("basic_q1", dut_px[5], SCAN ? 6'h10 : 6'h30);
         check("basic_q2", dut_px[6], SCAN ? 6'h04 : 6'h0C);
         check("basic_q3", dut_px[7], SCAN ? 6'h01 : 6'h03);
      end

      // overflow: 530 pixels into a 520-pixel buffer
      for (int i = 0; i < 530; i++) wr_px(6'(i));
      dut_px.delete();
      ls(0, 6'h00);
      check("ovf_len", int'(bus.line_len), 520);
      check("ovf_flag", int'(bus.overflow), 1);
      repeat (2500) step();
      check("ovf_npx", dut_px.size(), 1040);
      if (dut_px.size() == 1040) begin
         check("ovf_first", dut_px[0], 6'h00);
         check("ovf_last_p0", dut_px[519], 6'h07);
      end

      // simultaneous pixel + line start, followed by a zero-length replay
      dut_px.delete();
      ls(1, 6'h2A);
      check("sim_len_zero", int'(bus.line_len), 0);
      hs_low = 0;
      repeat (400) step();
      check("zero_len_npx", dut_px.size(), 0);
      check("zero_len_hs", hs_low, 128);
      wr_px(6'h11); wr_px(6'h22); wr_px(6'h33);
      dut_px.delete();
      ls(0, 6'h00);
      check("sim_len", int'(bus.line_len), 4);

      // truncation in pass 1 at rd_addr 2
      wait_px(6, 1000);
      ls(0, 6'h00);
      repeat (200) step();
      check("trunc_npx", dut_px.size(), 6);
      if (dut_px.size() >= 4) begin
         check("sim_p0", dut_px[0], 6'h2A);
         check("sim_p1", dut_px[1], 6'h11);
         check("sim_p3", dut_px[3], 6'h33);
      end

      // reset in the middle of a pass
      for (int i = 1; i <= 8; i++) wr_px(6'(i));
      dut_px.delete();
      ls(0, 6'h00);
      wait_px(2, 1000);
      rst = 1'b1;
      step();
      check_reset_pins("midrst");
      rst = 1'b0;
      dut_px.delete(); hs_low = 0;
      repeat (400) step();
      check("idle_npx", dut_px.size(), 0);
      check("idle_hs", hs_low, 0);
      wr_px(6'h05); wr_px(6'h09);
      ls(0, 6'h00);
      repeat (400) step();
      check("post_rst_npx", dut_px.size(), 4);
      if (dut_px.size() > 0) check("post_rst_p0", dut_px[0], 6'h05);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/vic_scandoubler.md
# vic_scandoubler

Line-doubling stage downstream of the per-pixel colour lookup. Captures each native-rate 6-bit RGB pixel (2 bits per channel) into a ping-pong line buffer and replays every completed line twice at double pixel rate, with its own output horizontal sync, to drive a 31 kHz VGA-class monitor. All logic runs on the single dot-clock domain. Input and output pixel rates are set by clock-enable strobes.

## Interface
Parameters:
- MAX_PIXELS, 520: capacity of each line buffer in pixels; also the maximum captured line length.
- HSYNC_WIDTH, 64: output hsync pulse width in output pixel strobes.
- BP_WIDTH, 24: output back-porch width in output pixel strobes, between the end of hsync and the first pixel of each pass.

Ports:
- clk_dot4x  in  1  sole clock; every register updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_pix_en  in  1  native pixel strobe; one pulse per incoming pixel.
- in_line_start  in  1  one-cycle pulse marking the start of a native line.
- in_red, in_green, in_blue  in  2 each  incoming colour sampled on in_pix_en.
- out_pix_en  in  1  output pixel strobe; nominally twice the in_pix_en rate.
- out_red, out_green, out_blue  out  2 each  registered output colour.
- out_hsync  out  1  output horizontal sync, active-low.
- out_active  out  1  high while a buffered pixel is being presented.
- line_len  out  10  length of the last completed captured line.
- overflow  out  1  sticky; set when a line exceeds MAX_PIXELS.

## Operation
- **Buffers:** two buffers of MAX_PIXELS × 6 bits. wr_sel selects the write buffer; reads use the other one.
- **Write side:**
  - On in_pix_en, when wr_count < MAX_PIXELS, store {in_red,in_green,in_blue} at wr_count, then increment wr_count.
  - When wr_count = MAX_PIXELS, discard the pixel, set overflow, and hold wr_count.
- **Line start:** on in_line_start:
  - Toggle wr_sel.
  - Copy wr_count to line_len, then clear wr_count.
  - Force the read FSM into SYNC with pass = 0, even if a pass is in progress.
- **Simultaneous in_pix_en and in_line_start:** the pixel is written at index 0 of the newly selected write buffer.
- **Read FSM:** it advances only on out_pix_en, except for the forced restart on in_line_start.
  - IDLE: stay until the first in_line_start after reset.
  - SYNC: hold out_hsync = 0 for HSYNC_WIDTH strobes, then go to PORCH.
  - PORCH: hold out_hsync = 1 for BP_WIDTH strobes, then go to PASS.
  - PASS: present buf[rd_addr] and increment rd_addr. After index line_len−1:
    - if pass = 0, set pass = 1, clear rd_addr, and go to SYNC;
    - if pass = 1, go to BLANK.
  - BLANK: output black with out_active = 0 until the next in_line_start.
- **Zero-length line:** when line_len = 0, PORCH goes directly to the following SYNC (pass 0) or to BLANK (pass 1). No pixel is presented.
- **Colour outside PASS:** out_red, out_green and out_blue are 0.
- **Reset:**
  - Registers: state = IDLE, wr_sel = 0, wr_count = 0, rd_addr = 0, pass = 0.
  - Outputs: line_len = 0, overflow = 0, out_rgb = 0, out_active = 0, out_hsync = 1.
  - Buffer contents are not cleared.
  - Reset asserted mid-line abandons both sides immediately.

## Timing
- **Buffer read:** synchronous with 1-cycle latency. The output register adds one more cycle.
- **Pixel latency:** colour, out_active and out_hsync change exactly 2 clk_dot4x cycles after the out_pix_en that produced them. All three stay aligned.
- **Line start:** out_hsync falls 2 cycles after the first out_pix_en following in_line_start.
- **Out-of-range writes:** writes and reads never touch the same buffer within one line.
- **Rate requirement:** out_pix_en must supply at least 2×(HSYNC_WIDTH+BP_WIDTH+line_len) strobes per native line. If it does not, the next in_line_start truncates pass 1 at once; out_active drops 2 cycles later.
- **Overflow flag:** clears only on rst.

## Configuration
- **VIC_SCANLINES_EN defined:** during pass 1, each presented channel value is shifted right by one (3→1, 2→1, 1→0), giving a dimmed scanline effect.
- **Undefined:** both passes present identical colour.

## Test plan
- **Basic doubling:** capture a 4-pixel line (RGB 0x3F, 0x30, 0x0C, 0x03), then in_line_start; out_pix_en every 2 cycles. Expect hsync low for 64 strobes, 24 porch strobes, then 0x3F, 0x30, 0x0C, 0x03 twice with out_active = 1, then BLANK.
- **Scanlines:** same stimulus with VIC_SCANLINES_EN. Expect pass 1 to show 0x15, 0x10, 0x04, 0x01.
- **Overflow:** 530 in_pix_en pulses, then in_line_start. Expect line_len = 520, overflow = 1, and pixel 519 as the last presented pixel.
- **Simultaneous strobes:** in_pix_en and in_line_start in the same cycle with colour 0x2A. Expect 0x2A as pixel 0 of the following line's playback.
- **Truncation:** in_line_start arrives in pass 1 at rd_addr = 2. Expect out_active to drop and out_hsync to fall on the next strobe (pass 0).
- **Reset:** rst mid-PASS. Expect all outputs at their reset values the next cycle, line_len = 0, and state IDLE until in_line_start.
